// File: rtl/tree_reduce_pkg.sv
// Shared types and per-node helpers for the pipelined bit-reduction tree.
// Reduction modes and the helpers used by every tree node.
package tree_reduce_pkg;

  typedef enum logic [1:0] {
    MODE_AND  = 2'd0,
    MODE_OR   = 2'd1,
    MODE_XOR  = 2'd2,
    MODE_NAND = 2'd3
  } mode_e;

  localparam int N_IN_MIN = 2;
  localparam int N_IN_MAX = 256;

  // Neutral element used to fill leaves beyond the real operand width.
  function automatic logic identity(input mode_e mode);
    return (mode == MODE_AND) || (mode == MODE_NAND);
  endfunction

  // NAND reduces as AND; the inversion happens once at the root.
  function automatic logic combine(input logic a, input logic b, input mode_e mode);
    logic r;
    case (mode)
      MODE_OR:  r = a | b;
      MODE_XOR: r = a ^ b;
      default:  r = a & b;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/tree_reduce_stage.sv
// One registered level of the reduction tree: halves the vector pairwise and
// carries the mode and valid bit alongside the data.
module tree_reduce_stage
  import tree_reduce_pkg::*;
#(
  parameter int WIDTH_IN    = 2,
  parameter bit INVERT_NAND = 1'b0
) (
  input  logic                  clk,
  input  logic                  i_rst,
  input  logic [WIDTH_IN-1:0]   i_vec,
  input  logic [1:0]            i_mode,
  input  logic                  i_valid,
  input  logic                  i_advance,
  output logic [WIDTH_IN/2-1:0] o_vec,
  output logic [1:0]            o_mode,
  output logic                  o_valid
);

  localparam int WIDTH_OUT = WIDTH_IN / 2;

  if ((WIDTH_IN % 2) != 0 || WIDTH_IN < 2) begin : g_bad_width
    $error("tree_reduce_stage: WIDTH_IN=%0d must be even and >= 2", WIDTH_IN);
  end

  logic [WIDTH_OUT-1:0] w_next;
  mode_e                w_mode;
  logic [WIDTH_OUT-1:0] r_vec;
  logic [1:0]           r_mode;
  logic                 r_valid;

  assign w_mode = mode_e'(i_mode);

  always_comb begin
    w_next = '0;
    for (int i = 0; i < WIDTH_OUT; i++) begin
      w_next[i] = combine(i_vec[2*i], i_vec[2*i+1], w_mode);
    end
    // Only the root stage is built with INVERT_NAND set.
    if (INVERT_NAND && (w_mode == MODE_NAND)) begin
      w_next = ~w_next;
    end
  end

  // The whole pipe moves in lockstep; a bubble shifts like any other slot.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      r_vec   <= '0;
      r_mode  <= '0;
      r_valid <= 1'b0;
    end else if (i_advance) begin
      r_vec   <= w_next;
      r_mode  <= i_mode;
      r_valid <= i_valid;
    end
  end

  assign o_vec   = r_vec;
  assign o_mode  = r_mode;
  assign o_valid = r_valid;

endmodule

// File: rtl/tree_reduce_pipe.sv
// Pipelined N_IN-to-1 bit reduction (AND/OR/XOR/NAND) with one register per
// tree level and a valid/ready handshake on both sides.
//
// Handshake: a side transfers on a cycle where valid && ready are both high.
// in_ready = !out_valid || out_ready and never depends on in_valid; the whole
// pipe either shifts or holds as one, and out/out_mode stay stable while
// out_valid && !out_ready.
module tree_reduce_pipe
  import tree_reduce_pkg::*;
#(
  parameter int N_IN = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_IN-1:0] in,
  input  logic [1:0]      in_mode,
  input  logic            in_valid,
  output logic            in_ready,
  output logic            out,
  output logic [1:0]      out_mode,
  output logic            out_valid,
  input  logic            out_ready
);

  localparam int LEVELS = $clog2(N_IN);
  localparam int LEAF   = 1 << LEVELS;

  if (N_IN < N_IN_MIN || N_IN > N_IN_MAX) begin : g_bad_n_in
    $error("tree_reduce_pipe: N_IN=%0d outside legal range 2..256", N_IN);
  end

  // w_node packs every stage output: stage k owns [LEAF-(LEAF>>k) +: LEAF>>(k+1)],
  // so the root lands on bit LEAF-2.
  logic [LEAF-1:0] w_leaf;
  logic [LEAF-2:0] w_node;
  logic [1:0]      w_mode  [LEVELS+1];
  logic            w_valid [LEVELS+1];
  logic            w_advance;

  assign w_leaf[N_IN-1:0] = in;

  if (LEAF > N_IN) begin : g_pad
    logic w_ident;
    assign w_ident                 = identity(mode_e'(in_mode));
    assign w_leaf[LEAF-1:N_IN]     = {(LEAF-N_IN){w_ident}};
  end

  assign w_mode[0]  = in_mode;
  assign w_valid[0] = in_valid;

  for (genvar k = 0; k < LEVELS; k++) begin : g_level
    localparam int W_IN  = LEAF >> k;
    localparam int W_OUT = W_IN / 2;

    logic [W_IN-1:0] w_stage_in;

    if (k == 0) begin : g_first
      assign w_stage_in = w_leaf;
    end else begin : g_inner
      assign w_stage_in = w_node[LEAF-2*W_IN +: W_IN];
    end

    tree_reduce_stage #(
      .WIDTH_IN    (W_IN),
      .INVERT_NAND (k == LEVELS-1)
    ) u_stage (
      .clk       (clk),
      .i_rst     (rst),
      .i_vec     (w_stage_in),
      .i_mode    (w_mode[k]),
      .i_valid   (w_valid[k]),
      .i_advance (w_advance),
      .o_vec     (w_node[LEAF-W_IN +: W_OUT]),
      .o_mode    (w_mode[k+1]),
      .o_valid   (w_valid[k+1])
    );
  end

  assign w_advance = !w_valid[LEVELS] || out_ready;
  assign in_ready  = w_advance;
  assign out       = w_node[LEAF-2];
  assign out_mode  = w_mode[LEVELS];
  assign out_valid = w_valid[LEVELS];

endmodule

// File: tb/tb_tree_reduce_pipe.sv
// Self-checking bench for tree_reduce_pipe at N_IN = 8, 5 and 2, compared
// against a population-count reference of each reduction mode.
module tb_tree_reduce_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  logic [2:0] exp_q[$];   // {out, out_mode}
  int         acc_q[$];

  logic [7:0] d8_in = '0;
  logic [1:0] d8_in_mode = '0;
  logic       d8_in_valid = 1'b0, d8_out_ready = 1'b1;
  logic       d8_in_ready, d8_out, d8_out_valid;
  logic [1:0] d8_out_mode;

  logic [4:0] d5_in = '0;
  logic [1:0] d5_in_mode = '0;
  logic       d5_in_valid = 1'b0, d5_out_ready = 1'b1;
  logic       d5_in_ready, d5_out, d5_out_valid;
  logic [1:0] d5_out_mode;

  logic [1:0] d2_in = '0;
  logic [1:0] d2_in_mode = '0;
  logic       d2_in_valid = 1'b0, d2_out_ready = 1'b1;
  logic       d2_in_ready, d2_out, d2_out_valid;
  logic [1:0] d2_out_mode;

  tree_reduce_pipe #(.N_IN(8)) u_dut8 (
    .clk(clk), .rst(rst), .in(d8_in), .in_mode(d8_in_mode), .in_valid(d8_in_valid),
    .in_ready(d8_in_ready), .out(d8_out), .out_mode(d8_out_mode),
    .out_valid(d8_out_valid), .out_ready(d8_out_ready));

  tree_reduce_pipe #(.N_IN(5)) u_dut5 (
    .clk(clk), .rst(rst), .in(d5_in), .in_mode(d5_in_mode), .in_valid(d5_in_valid),
    .in_ready(d5_in_ready), .out(d5_out), .out_mode(d5_out_mode),
    .out_valid(d5_out_valid), .out_ready(d5_out_ready));

  tree_reduce_pipe #(.N_IN(2)) u_dut2 (
    .clk(clk), .rst(rst), .in(d2_in), .in_mode(d2_in_mode), .in_valid(d2_in_valid),
    .in_ready(d2_in_ready), .out(d2_out), .out_mode(d2_out_mode),
    .out_valid(d2_out_valid), .out_ready(d2_out_ready));

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  // ---------------- reference model ----------------
  function automatic logic ref_reduce(input logic [255:0] v, input int n, input logic [1:0] mode);
    int ones = 0;
    for (int i = 0; i < n; i++) ones += int'(v[i]);
    case (mode)
      2'd0:    return ones == n;
      2'd1:    return ones != 0;
      2'd2:    return (ones % 2) == 1;
      default: return ones != n;
    endcase
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++; if (d8_out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid_8: got %b want 0", d8_out_valid); end
    total++; if (d8_out !== 1'b0) begin bad++; $display("FAIL reset_out_8: got %b want 0", d8_out); end
    total++; if (d8_out_mode !== 2'd0) begin bad++; $display("FAIL reset_out_mode_8: got %0d want 0", d8_out_mode); end
    total++; if (d5_out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid_5: got %b want 0", d5_out_valid); end
    total++; if (d2_out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid_2: got %b want 0", d2_out_valid); end
    rst = 1'b0;
    @(negedge clk);
    total++; if (d8_in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready_8: got %b want 1", d8_in_ready); end
    total++; if (d5_in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready_5: got %b want 1", d5_in_ready); end
    total++; if (d2_in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready_2: got %b want 1", d2_in_ready); end
  endtask

  task automatic test_and_latency();
    logic [7:0] vecs [2];
    logic       exp_bit, got;
    logic [1:0] got_mode;
    int         lat;
    vecs[0] = 8'hFF;
    vecs[1] = 8'hFE;
    for (int t = 0; t < 2; t++) begin
      exp_bit = ref_reduce(256'(vecs[t]), 8, 2'd0);
      @(negedge clk);
      d8_in = vecs[t]; d8_in_mode = 2'd0; d8_in_valid = 1'b1; d8_out_ready = 1'b1;
      #1;
      total++; if (d8_in_ready !== 1'b1) begin bad++; $display("FAIL and_in_ready[%0d]: got %b want 1", t, d8_in_ready); end
      @(posedge clk); #1;
      d8_in_valid = 1'b0;
      lat = 0; got = 1'bx; got_mode = 2'bxx;
      for (int n = 1; n <= 10 && lat == 0; n++) begin
        @(negedge clk);
        if (d8_out_valid === 1'b1) begin lat = n; got = d8_out; got_mode = d8_out_mode; end
      end
      total++; if (lat != 3) begin bad++; $display("FAIL and_latency[%0d]: got %0d want 3", t, lat); end
      total++; if (got !== exp_bit) begin bad++; $display("FAIL and_out[%0d]: got %b want %b", t, got, exp_bit); end
      total++; if (got_mode !== 2'd0) begin bad++; $display("FAIL and_out_mode[%0d]: got %0d want 0", t, got_mode); end
    end
  endtask

  task automatic test_back_to_back();
    int         sent = 0, seen = 0, last_cyc = 0;
    logic [2:0] e;
    exp_q.delete();
    d8_out_ready = 1'b1;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      if (d8_out_valid === 1'b1) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 3'bxxx;
        total++; if ({d8_out, d8_out_mode} !== e) begin bad++; $display("FAIL b2b_result[%0d]: got out=%b mode=%0d want out=%b mode=%0d", seen, d8_out, d8_out_mode, e[2], e[1:0]); end
        if (seen > 0) begin
          total++; if (cyc != last_cyc + 1) begin bad++; $display("FAIL b2b_consecutive[%0d]: got cycle %0d want %0d", seen, cyc, last_cyc + 1); end
        end
        last_cyc = cyc;
        seen++;
      end
      if (sent < 4) begin
        d8_in = 8'h01; d8_in_mode = 2'(sent); d8_in_valid = 1'b1;
        exp_q.push_back({ref_reduce(256'(8'h01), 8, 2'(sent)), 2'(sent)});
        sent++;
      end else begin
        d8_in_valid = 1'b0;
      end
    end
    total++; if (seen != 4) begin bad++; $display("FAIL b2b_count: got %0d want 4", seen); end
  endtask

  task automatic test_padding();
    logic [4:0] vec;
    logic [1:0] mode;
    logic       exp_bit, got;
    logic [1:0] got_mode;
    int         lat;
    for (int t = 0; t < 12; t++) begin
      case (t)
        0:       begin vec = 5'h1F; mode = 2'd0; end
        1:       begin vec = 5'h00; mode = 2'd1; end
        2:       begin vec = 5'h07; mode = 2'd2; end
        default: begin vec = 5'($urandom_range(0, 31)); mode = 2'($urandom_range(0, 3)); end
      endcase
      exp_bit = ref_reduce(256'(vec), 5, mode);
      @(negedge clk);
      d5_in = vec; d5_in_mode = mode; d5_in_valid = 1'b1; d5_out_ready = 1'b1;
      #1;
      total++; if (d5_in_ready !== 1'b1) begin bad++; $display("FAIL pad_in_ready[%0d]: got %b want 1", t, d5_in_ready); end
      @(posedge clk); #1;
      d5_in_valid = 1'b0;
      lat = 0; got = 1'bx; got_mode = 2'bxx;
      for (int n = 1; n <= 10 && lat == 0; n++) begin
        @(negedge clk);
        if (d5_out_valid === 1'b1) begin lat = n; got = d5_out; got_mode = d5_out_mode; end
      end
      total++; if (lat != 3) begin bad++; $display("FAIL pad_latency[%0d]: got %0d want 3", t, lat); end
      total++; if (got !== exp_bit) begin bad++; $display("FAIL pad_out[%0d] in=%h mode=%0d: got %b want %b", t, vec, mode, got, exp_bit); end
      total++; if (got_mode !== mode) begin bad++; $display("FAIL pad_out_mode[%0d]: got %0d want %0d", t, got_mode, mode); end
    end
  endtask

  task automatic test_backpressure();
    int         sent = 0, seen = 0, extra = 0;
    logic       prev_stall = 1'b0, acc_last = 1'b0;
    logic [2:0] prev_word = '0, word, e;
    exp_q.delete();
    for (int c = 0; c < 60 && seen < 5; c++) begin
      @(negedge clk);
      if (acc_last) d8_in_valid = 1'b0;
      acc_last = 1'b0;
      d8_out_ready = (c >= 7);
      if (!d8_in_valid && sent < 5) begin
        d8_in = 8'($urandom_range(0, 255)); d8_in_mode = 2'($urandom_range(0, 3)); d8_in_valid = 1'b1;
      end
      #1;
      word = {d8_out, d8_out_mode};
      if (d8_out_valid === 1'b1) begin
        if (prev_stall) begin
          total++; if (word !== prev_word) begin bad++; $display("FAIL bp_stable: got %b want %b", word, prev_word); end
        end
        if (!d8_out_ready) begin
          total++; if (d8_in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready: got %b want 0", d8_in_ready); end
        end else begin
          e = (exp_q.size() > 0) ? exp_q.pop_front() : 3'bxxx;
          total++; if (word !== e) begin bad++; $display("FAIL bp_result[%0d]: got %b want %b", seen, word, e); end
          seen++;
        end
      end
      prev_stall = (d8_out_valid === 1'b1) && !d8_out_ready;
      prev_word  = word;
      if (d8_in_valid && d8_in_ready === 1'b1) begin
        exp_q.push_back({ref_reduce(256'(d8_in), 8, d8_in_mode), d8_in_mode});
        sent++;
        acc_last = 1'b1;
      end
    end
    @(negedge clk);
    d8_in_valid = 1'b0;
    total++; if (seen != 5) begin bad++; $display("FAIL bp_count: got %0d want 5", seen); end
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (d8_out_valid === 1'b1) extra++;
    end
    total++; if (extra != 0) begin bad++; $display("FAIL bp_duplicate: got %0d extra outputs want 0", extra); end
  endtask

  task automatic test_reset_mid();
    int stale = 0;
    @(negedge clk);
    d8_out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      d8_in = 8'($urandom_range(0, 255)); d8_in_mode = 2'($urandom_range(0, 3)); d8_in_valid = 1'b1;
      @(negedge clk);
    end
    d8_in_valid = 1'b0;
    #1;
    total++; if (d8_out_valid !== 1'b1) begin bad++; $display("FAIL rst_mid_pre_valid: got %b want 1", d8_out_valid); end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    total++; if (d8_out_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_out_valid: got %b want 0", d8_out_valid); end
    total++; if ({d8_out, d8_out_mode} !== 3'b000) begin bad++; $display("FAIL rst_mid_out: got %b want 000", {d8_out, d8_out_mode}); end
    rst = 1'b0;
    d8_out_ready = 1'b1;
    @(negedge clk);
    total++; if (d8_in_ready !== 1'b1) begin bad++; $display("FAIL rst_mid_in_ready: got %b want 1", d8_in_ready); end
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (d8_out_valid !== 1'b0) stale++;
    end
    total++; if (stale != 0) begin bad++; $display("FAIL rst_mid_stale: got %0d stale cycles want 0", stale); end
  endtask

  task automatic test_random_n2();
    int         sent = 0, seen = 0;
    logic       prev_stall = 1'b0;
    logic [2:0] e;
    exp_q.delete();
    acc_q.delete();
    for (int c = 0; c < 6000 && seen < 1000; c++) begin
      @(negedge clk);
      d2_in_valid  = (sent < 1000) && ($urandom_range(0, 3) != 0);
      d2_in        = 2'($urandom_range(0, 3));
      d2_in_mode   = 2'($urandom_range(0, 3));
      d2_out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (d2_out_valid === 1'b1) begin
        if (!prev_stall) begin
          total++; if (acc_q.size() == 0 || cyc != acc_q[0] + 1) begin bad++; $display("FAIL n2_latency[%0d]: appeared cycle %0d, queued %0d", seen, cyc, acc_q.size()); end
        end
        if (d2_out_ready) begin
          e = (exp_q.size() > 0) ? exp_q.pop_front() : 3'bxxx;
          if (acc_q.size() > 0) void'(acc_q.pop_front());
          total++; if ({d2_out, d2_out_mode} !== e) begin bad++; $display("FAIL n2_result[%0d]: got out=%b mode=%0d want out=%b mode=%0d", seen, d2_out, d2_out_mode, e[2], e[1:0]); end
          seen++;
        end
      end
      prev_stall = (d2_out_valid === 1'b1) && !d2_out_ready;
      if (d2_in_valid && d2_in_ready === 1'b1) begin
        exp_q.push_back({ref_reduce(256'(d2_in), 2, d2_in_mode), d2_in_mode});
        acc_q.push_back(cyc);
        sent++;
      end
    end
    @(negedge clk);
    d2_in_valid = 1'b0;
    total++; if (seen != 1000) begin bad++; $display("FAIL n2_count: got %0d want 1000", seen); end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL n2_leftover: got %0d want 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_and_latency();
    test_back_to_back();
    test_padding();
    test_backpressure();
    test_reset_mid();
    test_random_n2();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tree_reduce_pipe.md
Name: tree_reduce_pipe

Overview:
- Parametrised, pipelined successor to the fixed 8-input combinational AND tree.
- Reduces N_IN input bits to a single bit through a balanced binary tree, with one register stage per tree level.
- Reduction operation is selectable per transaction: AND, OR, XOR or NAND.
- Valid/ready handshake with full backpressure; sits between a bit-vector producer and a single-bit consumer in the synthetic tree-benchmark family.

Parameters:
- N_IN, 8: number of input bits; legal range 2..256; need not be a power of two.
- LEVELS, $clog2(N_IN): derived, not overridable; tree depth, equal to pipeline latency in cycles.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in  input  N_IN  operand bit-vector.
- in_mode  input  2  operation: 0 AND, 1 OR, 2 XOR, 3 NAND.
- in_valid  input  1  in/in_mode valid this cycle.
- in_ready  output  1  block accepts input this cycle.
- out  output  1  reduction result.
- out_mode  output  2  mode that produced out.
- out_valid  output  1  out/out_mode valid.
- out_ready  input  1  consumer accepts out this cycle.

Behaviour:
- Clock/reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values: all stage valid bits 0, all stage data and mode registers 0. Hence out=0, out_mode=0, out_valid=0 from the first cycle after rst is sampled high.
- Reset mid-operation: in-flight transactions are discarded, not flushed. in_ready=1 in the cycle after reset deasserts.
- Padding: leaf vector width is 2**LEVELS. Bits at index >= N_IN are filled with the identity of the captured mode: 1 for AND/NAND, 0 for OR/XOR.
- Stage 0: on accept, stage-0 registers capture the first pairwise level applied to the padded input, plus in_mode. NAND uses AND internally.
- Stage k (1..LEVELS-1): registers the pairwise reduction of stage k-1 using the mode carried with that data. Mode travels alongside its data, so mixed modes in flight are legal.
- Output: out is the final register; NAND inversion is applied at the final register input.
- Latency: an input accepted at cycle t appears on out_valid at cycle t+LEVELS, provided no stall.
- Throughput: one transaction per cycle.
- Handshake:
  - advance = !out_valid || out_ready; in_ready = advance.
  - Accept = in_valid && in_ready.
  - When advance=0, every stage (data, mode and valid) holds; no bubble squeezing.
  - When advance=1, every stage shifts. A stage whose predecessor is invalid loads valid=0; its data is don't-care, held to the shifted value.
  - out/out_mode are stable while out_valid && !out_ready.
  - in_valid may drop without an accept and is not sticky; in_ready does not depend on in_valid.
- Simultaneous events:
  - If the output is consumed and a new input is accepted in the same cycle, both take effect.
  - rst overrides all.
- Width rule: every node is 1 bit; no arithmetic. N_IN=2 gives LEVELS=1, a single register stage.
- Illegal: N_IN < 2 or N_IN > 256 must fail elaboration via an assertion.

Decomposition:
- Package tree_reduce_pkg:
  - Mode enum: MODE_AND=0, MODE_OR=1, MODE_XOR=2, MODE_NAND=3.
  - Function identity(mode).
  - Function combine(a, b, mode).
- Sub-module tree_reduce_stage: one registered tree level, parametrised by WIDTH_IN (even).
  - Inputs: vector, mode, valid, advance, rst.
  - Outputs: WIDTH_IN/2 vector, mode, valid.
- Top level: padding, generate loop over LEVELS stage instances, final NAND inversion, handshake logic.

Test Plan:
- N_IN=8, in=8'hFF, mode AND, out_ready=1 -> out=1 and out_valid exactly 3 cycles after accept; in=8'hFE -> out=0.
- N_IN=8, back-to-back accepts with modes AND, OR, XOR, NAND on in=8'h01 -> results 0, 1, 1, 1 on consecutive cycles, out_mode 0, 1, 2, 3 in order.
- N_IN=5 (LEVELS=3):
  - in=5'h1F AND -> 1.
  - in=5'h00 OR -> 0.
  - in=5'h07 XOR -> 1.
  - These confirm identity padding.
- Backpressure, N_IN=8: hold out_ready=0 for 4 cycles while streaming 5 inputs -> in_ready drops once out_valid=1, out is stable, no loss or duplication; order preserved after release.
- Reset mid-stream: assert rst for 1 cycle with 3 transactions in flight -> out_valid=0 next cycle, no stale result emerges, in_ready=1.
- N_IN=2, random 1000 transactions with random in_valid/out_ready against a scoreboard -> latency 1, all results match reference reductions.
